// File: rtl/char_write_scheduler_pkg.sv
// Shared terminal geometry and scheduler state encoding, used by the
// command handler, the char buffer and the char write scheduler.
package char_write_scheduler_pkg;

   localparam int unsigned TERM_ROWS      = 25;
   localparam int unsigned TERM_COLS      = 80;
   localparam int unsigned TERM_ADDR_BITS = 11;
   localparam int unsigned TERM_CELLS     = TERM_ROWS * TERM_COLS;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } sched_state_e;

endpackage

// File: rtl/char_write_scheduler_fill.sv
// Fill address generator: wrapping cell address plus remaining-write counter.
// Out-of-range start addresses restart at cell 0, and counts are clamped to the screen size.
module fill_counter
   import char_write_scheduler_pkg::*;
#(
   parameter int unsigned ADDR_BITS = TERM_ADDR_BITS,
   parameter int unsigned CELLS     = TERM_CELLS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_i,
   input  logic [ADDR_BITS-1:0] start_addr_i,
   input  logic [ADDR_BITS:0]   count_i,
   input  logic                 step_i,
   output logic [ADDR_BITS-1:0] addr_o,
   output logic                 last_o
);

   localparam int unsigned          CW        = ADDR_BITS + 1;
   localparam logic [CW-1:0]        CELLS_C   = CW'(CELLS);
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(CELLS - 1);

   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [CW-1:0]        rem_q, rem_d;

   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (load_i) begin
         addr_d = ({1'b0, start_addr_i} >= CELLS_C) ? '0 : start_addr_i;
         rem_d  = (count_i > CELLS_C) ? CELLS_C : count_i;
      end else if (step_i) begin
         addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_BITS'(1);
         rem_d  = rem_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
      end
   end

   assign addr_o = addr_q;
   assign last_o = (rem_q == CW'(1));

endmodule

// File: rtl/char_write_scheduler.sv
// Single-port char buffer write scheduler: round-robin between two requesters,
// with a fill engine that takes over the port while clearing a cell range.
module char_write_scheduler
   import char_write_scheduler_pkg::*;
#(
   parameter int unsigned ROWS      = TERM_ROWS,
   parameter int unsigned COLS      = TERM_COLS,
   parameter int unsigned ADDR_BITS = TERM_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [ADDR_BITS-1:0] a_addr,
   input  logic [7:0]           a_char,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [ADDR_BITS-1:0] b_addr,
   input  logic [7:0]           b_char,
   input  logic                 clr_start,
   input  logic [ADDR_BITS-1:0] clr_addr,
   input  logic [ADDR_BITS:0]   clr_count,
   input  logic [7:0]           clr_char,
   output logic                 clr_busy,
   output logic                 clr_done,
   output logic                 wen,
   output logic [ADDR_BITS-1:0] waddr,
   output logic [7:0]           wdata,
   output logic                 range_err
);

   localparam int unsigned   CELLS   = ROWS * COLS;
   localparam int unsigned   CW      = ADDR_BITS + 1;
   localparam logic [CW-1:0] CELLS_C = CW'(CELLS);

   sched_state_e state_q, state_d;

   logic                 wen_q, wen_d;
   logic [ADDR_BITS-1:0] waddr_q, waddr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 range_err_q, range_err_d;
   logic                 done_q, done_d;
   logic                 busy_q;
   logic                 gnt_b_last_q, gnt_b_last_d;
   logic [7:0]           char_q, char_d;

   logic                 fc_load, fc_step, fc_last;
   logic [ADDR_BITS-1:0] fc_addr;

   fill_counter #(
      .ADDR_BITS (ADDR_BITS),
      .CELLS     (CELLS)
   ) u_fill_counter (
      .clk          (clk),
      .reset        (reset),
      .load_i       (fc_load),
      .start_addr_i (clr_addr),
      .count_i      (clr_count),
      .step_i       (fc_step),
      .addr_o       (fc_addr),
      .last_o       (fc_last)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (clr_start && (clr_count != '0)) state_d = ST_FILL;
         ST_FILL: if (fc_last) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Arbitration, fill write generation and next values of the registered outputs.
   always_comb begin
      a_ready      = 1'b0;
      b_ready      = 1'b0;
      wen_d        = 1'b0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      range_err_d  = 1'b0;
      done_d       = 1'b0;
      gnt_b_last_d = gnt_b_last_q;
      char_d       = char_q;
      fc_load      = 1'b0;
      fc_step      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clr_start) begin
               fc_load = 1'b1;
               char_d  = clr_char;
               if (clr_count == '0) done_d = 1'b1;
            end else if (!reset) begin
               a_ready = a_valid && (!b_valid || gnt_b_last_q);
               b_ready = b_valid && !a_ready;
               if (a_ready) begin
                  gnt_b_last_d = 1'b0;
                  if ({1'b0, a_addr} >= CELLS_C) begin
                     range_err_d = 1'b1;
                  end else begin
                     wen_d   = 1'b1;
                     waddr_d = a_addr;
                     wdata_d = a_char;
                  end
               end else if (b_ready) begin
                  gnt_b_last_d = 1'b1;
                  if ({1'b0, b_addr} >= CELLS_C) begin
                     range_err_d = 1'b1;
                  end else begin
                     wen_d   = 1'b1;
                     waddr_d = b_addr;
                     wdata_d = b_char;
                  end
               end
            end
         end
         ST_FILL: begin
            fc_step = 1'b1;
            wen_d   = 1'b1;
            waddr_d = fc_addr;
            wdata_d = char_q;
            if (fc_last) done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wen_q        <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         range_err_q  <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         gnt_b_last_q <= 1'b1;
         char_q       <= '0;
      end else begin
         wen_q        <= wen_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         range_err_q  <= range_err_d;
         done_q       <= done_d;
         busy_q       <= (state_d == ST_FILL);
         gnt_b_last_q <= gnt_b_last_d;
         char_q       <= char_d;
      end
   end

   assign wen       = wen_q;
   assign waddr     = waddr_q;
   assign wdata     = wdata_q;
   assign range_err = range_err_q;
   assign clr_done  = done_q;
   assign clr_busy  = busy_q;

endmodule

// File: tb/tb_char_write_scheduler.sv
// Directed bench for char_write_scheduler: stimulus pushes expected buffer
// writes into a queue, a negedge monitor pops and compares every wen.
module tb_char_write_scheduler;

   logic        clk;
   logic        reset;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [10:0] a_addr, b_addr;
   logic [7:0]  a_char, b_char;
   logic        clr_start;
   logic [10:0] clr_addr;
   logic [11:0] clr_count;
   logic [7:0]  clr_char;
   logic        clr_busy, clr_done;
   logic        wen;
   logic [10:0] waddr;
   logic [7:0]  wdata;
   logic        range_err;

   typedef struct packed {
      logic [10:0] addr;
      logic [7:0]  data;
   } exp_wr_t;

   exp_wr_t exp_q[$];
   int      n_checks  = 0;
   int      n_fail    = 0;
   int      wen_count = 0;

   char_write_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_addr    (a_addr),
      .a_char    (a_char),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_addr    (b_addr),
      .b_char    (b_char),
      .clr_start (clr_start),
      .clr_addr  (clr_addr),
      .clr_count (clr_count),
      .clr_char  (clr_char),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .wen       (wen),
      .waddr     (waddr),
      .wdata     (wdata),
      .range_err (range_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_wr(input int a, input int d);
      exp_q.push_back('{addr: 11'(a), data: 8'(d)});
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor for every char buffer write
   always @(negedge clk) begin
      if (wen === 1'b1) begin
         exp_wr_t e;
         wen_count++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %0h expected no write", waddr, wdata);
         end else begin
            e = exp_q.pop_front();
            if (waddr !== e.addr || wdata !== e.data) begin
               n_fail++;
               $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                        waddr, wdata, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int busy_cnt;
      bit done_seen;
      int wen_base;

      reset = 1'b1;
      a_valid = 1'b1; a_addr = 11'd10; a_char = 8'h61;
      b_valid = 1'b1; b_addr = 11'd20; b_char = 8'h62;
      clr_start = 1'b0; clr_addr = '0; clr_count = '0; clr_char = '0;

      // Reset: readies held low, registered outputs cleared
      to_next();
      to_neg();
      chk("rst_a_ready", 32'(a_ready), 32'd0);
      chk("rst_b_ready", 32'(b_ready), 32'd0);
      to_next();
      to_neg();
      chk("rst_wen", 32'(wen), 32'd0);
      chk("rst_waddr", 32'(waddr), 32'd0);
      chk("rst_wdata", 32'(wdata), 32'd0);
      chk("rst_busy", 32'(clr_busy), 32'd0);
      chk("rst_done", 32'(clr_done), 32'd0);
      chk("rst_range_err", 32'(range_err), 32'd0);
      to_next();

      // Contention straight after reset: A, B, A, B
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         to_neg();
         chk("rr_a_ready", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_b_ready", 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
         if (i % 2 == 0) push_wr(10, 8'h61);
         else            push_wr(20, 8'h62);
         to_next();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      to_next();

      // Lone A request
      a_valid = 1'b1; a_addr = 11'd5; a_char = 8'h41;
      to_neg();
      chk("lone_a_ready", 32'(a_ready), 32'd1);
      push_wr(5, 8'h41);
      to_next();
      a_valid = 1'b0;
      to_neg();
      chk("lone_a_wen", 32'(wen), 32'd1);
      chk("lone_a_waddr", 32'(waddr), 32'd5);
      chk("lone_a_wdata", 32'(wdata), 32'h41);
      to_next();

      // Back-to-back accepts of a sole requester
      for (int i = 0; i < 3; i++) begin
         a_valid = 1'b1; a_addr = 11'(100 + i); a_char = 8'(8'h30 + i);
         to_neg();
         chk("b2b_a_ready", 32'(a_ready), 32'd1);
         push_wr(100 + i, 8'h30 + i);
         to_next();
      end
      a_valid = 1'b0;

      // Out-of-range B request: accepted, no write, range_err pulse
      b_valid = 1'b1; b_addr = 11'd2047; b_char = 8'h77;
      to_neg();
      chk("oor_b_ready", 32'(b_ready), 32'd1);
      to_next();
      b_valid = 1'b0;
      to_neg();
      chk("oor_wen", 32'(wen), 32'd0);
      chk("oor_range_err", 32'(range_err), 32'd1);
      chk("oor_waddr_hold", 32'(waddr), 32'd102);
      chk("oor_wdata_hold", 32'(wdata), 32'h32);
      to_next();
      to_neg();
      chk("oor_range_err_end", 32'(range_err), 32'd0);
      to_next();

      // Wrapping fill of 4 cells with A held pending; a second clr_start is ignored
      clr_start = 1'b1; clr_addr = 11'd1998; clr_count = 12'd4; clr_char = 8'h20;
      a_valid = 1'b1; a_addr = 11'd7; a_char = 8'h5A;
      to_neg();
      chk("fill_start_a_ready", 32'(a_ready), 32'd0);
      chk("fill_start_busy", 32'(clr_busy), 32'd0);
      push_wr(1998, 8'h20);
      push_wr(1999, 8'h20);
      push_wr(0, 8'h20);
      push_wr(1, 8'h20);
      push_wr(7, 8'h5A);
      to_next();
      for (int i = 1; i <= 4; i++) begin
         clr_start = (i == 2);
         clr_addr = 11'd100; clr_count = 12'd2; clr_char = 8'h55;
         to_neg();
         chk("fill_busy", 32'(clr_busy), 32'd1);
         chk("fill_a_ready", 32'(a_ready), 32'd0);
         chk("fill_done_early", 32'(clr_done), 32'd0);
         to_next();
      end
      clr_start = 1'b0;
      to_neg();
      chk("fill_busy_end", 32'(clr_busy), 32'd0);
      chk("fill_done", 32'(clr_done), 32'd1);
      chk("fill_last_waddr", 32'(waddr), 32'd1);
      chk("post_fill_a_ready", 32'(a_ready), 32'd1);
      to_next();
      a_valid = 1'b0;
      to_neg();
      chk("fill_done_pulse", 32'(clr_done), 32'd0);
      to_next();

      // Pointer after fill: A was last granted, so B wins contention
      a_valid = 1'b1; a_addr = 11'd300; a_char = 8'h01;
      b_valid = 1'b1; b_addr = 11'd301; b_char = 8'h02;
      to_neg();
      chk("ptr_a_ready", 32'(a_ready), 32'd0);
      chk("ptr_b_ready", 32'(b_ready), 32'd1);
      push_wr(301, 8'h02);
      to_next();
      a_valid = 1'b0; b_valid = 1'b0;
      to_next();

      // Zero-count fill: no writes, done next cycle, never busy
      clr_start = 1'b1; clr_addr = 11'd3; clr_count = 12'd0; clr_char = 8'h78;
      to_next();
      clr_start = 1'b0;
      to_neg();
      chk("zero_done", 32'(clr_done), 32'd1);
      chk("zero_busy", 32'(clr_busy), 32'd0);
      to_next();
      to_neg();
      chk("zero_done_pulse", 32'(clr_done), 32'd0);
      to_next();

      // Oversized count clamps to the full screen
      wen_base = wen_count;
      for (int i = 0; i < 2000; i++) push_wr(i, 8'h2E);
      clr_start = 1'b1; clr_addr = 11'd0; clr_count = 12'd3000; clr_char = 8'h2E;
      to_next();
      clr_start = 1'b0;
      busy_cnt = 0;
      done_seen = 1'b0;
      for (int c = 0; c < 2100; c++) begin
         to_neg();
         if (clr_busy === 1'b1) busy_cnt++;
         if (clr_done === 1'b1) begin
            done_seen = 1'b1;
            break;
         end
         to_next();
      end
      chk("full_done_seen", 32'(done_seen), 32'd1);
      chk("full_busy_cycles", 32'(busy_cnt), 32'd2000);
      to_next();
      chk("full_write_count", 32'(wen_count - wen_base), 32'd2000);
      to_next();

      // Reset in the middle of an 80-cell fill, on the 10th write
      for (int i = 0; i < 10; i++) push_wr(i, 8'h2D);
      clr_start = 1'b1; clr_addr = 11'd0; clr_count = 12'd80; clr_char = 8'h2D;
      to_next();
      clr_start = 1'b0;
      for (int i = 0; i < 10; i++) to_next();
      reset = 1'b1;
      to_neg();
      chk("abort_wen_at_reset", 32'(wen), 32'd1);
      to_next();
      reset = 1'b0;
      to_neg();
      chk("abort_wen", 32'(wen), 32'd0);
      chk("abort_busy", 32'(clr_busy), 32'd0);
      chk("abort_done", 32'(clr_done), 32'd0);
      to_next();
      for (int i = 0; i < 3; i++) begin
         to_neg();
         chk("abort_no_done", 32'(clr_done), 32'd0);
         to_next();
      end

      // Fresh fill after reset
      clr_start = 1'b1; clr_addr = 11'd50; clr_count = 12'd3; clr_char = 8'h31;
      push_wr(50, 8'h31);
      push_wr(51, 8'h31);
      push_wr(52, 8'h31);
      to_next();
      clr_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         to_neg();
         chk("refill_busy", 32'(clr_busy), 32'd1);
         to_next();
      end
      to_neg();
      chk("refill_done", 32'(clr_done), 32'd1);
      chk("refill_busy_end", 32'(clr_busy), 32'd0);
      to_next();

      for (int i = 0; i < 3; i++) to_next();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/char_write_scheduler.md
CHAR_WRITE_SCHEDULER -- requirements
Module: char_write_scheduler

Interface
REQ-001 SHALL have parameters: ROWS, 25, text rows; COLS, 80, text columns; ADDR_BITS, 11, char buffer address width; CELLS = ROWS*COLS (derived), 2000.
REQ-002 SHALL have ports, one per line (name direction width meaning):
 clk  in  1  single clock (video/char-buffer domain)
 reset  in  1  synchronous, active-high
 a_valid  in  1  requester A (command handler) write request
 a_ready  out  1  requester A accepted this cycle when high with a_valid
 a_addr  in  ADDR_BITS  requester A cell address
 a_char  in  8  requester A character
 b_valid  in  1  requester B (status/overlay writer) write request
 b_ready  out  1  requester B accept
 b_addr  in  ADDR_BITS  requester B cell address
 b_char  in  8  requester B character
 clr_start  in  1  one-cycle pulse: start fill
 clr_addr  in  ADDR_BITS  first cell to fill
 clr_count  in  ADDR_BITS+1  number of cells to fill
 clr_char  in  8  fill character
 clr_busy  out  1  fill in progress
 clr_done  out  1  one-cycle pulse: fill completed
 wen  out  1  char buffer write enable
 waddr  out  ADDR_BITS  char buffer write address
 wdata  out  8  char buffer write data
 range_err  out  1  one-cycle pulse: accepted request had address >= CELLS

Function
REQ-003 SHALL issue at most one char buffer write per clk cycle.
REQ-004 SHALL register wen/waddr/wdata: a write accepted or generated in cycle N appears on the outputs in cycle N+1; wen low otherwise, waddr/wdata hold last value.
REQ-005 SHALL use two states: IDLE (serve requesters), FILL (clear engine owns the port).
REQ-006 SHALL, in IDLE, drive a_ready/b_ready combinationally: only one high per cycle, never high in FILL or in a cycle where clr_start is high.
REQ-007 SHALL arbitrate round-robin in IDLE: if only one valid, grant it; if both valid, grant the requester not granted last; last-grant pointer updates only on an actual accept.
REQ-008 SHALL keep ready high for a sole valid requester (no bubble); back-to-back accepts of the same requester allowed when the other is idle.
REQ-009 SHALL accept but not write a request with address >= CELLS: wen stays low, range_err pulses in the following cycle.
REQ-010 SHALL, on clr_start in IDLE, latch clr_addr, clr_char and effective count = min(clr_count, CELLS); clr_start has priority over any requester that cycle.
REQ-011 SHALL, if latched clr_addr >= CELLS, treat it as 0.
REQ-012 SHALL, in FILL, generate one write per cycle starting at the latched address, incrementing by 1 and wrapping CELLS-1 -> 0, until count writes issued.
REQ-013 SHALL enter FILL on the cycle after clr_start; clr_busy high for exactly the FILL cycles; clr_done pulses one cycle in the cycle after the last fill write is accepted (coincident with last wen), then return to IDLE.
REQ-014 SHALL, for effective count 0, skip FILL: no writes, clr_done pulses in the cycle after clr_start, clr_busy stays low.
REQ-015 SHALL ignore clr_start while clr_busy is high (no restart, no latch).
REQ-016 SHALL hold pending requester valids unaffected during FILL; arbitration resumes in the first IDLE cycle with the pointer unchanged.

Reset
REQ-017 SHALL on reset: state IDLE, wen 0, waddr 0, wdata 0, clr_busy 0, clr_done 0, range_err 0, a_ready/b_ready 0 during reset, last-grant = B (so A wins first contention).
REQ-018 SHALL abort an in-progress fill on reset without issuing clr_done; no wen in the cycle after reset asserts.

Structure
REQ-019 SHALL take ROWS, COLS, ADDR_BITS, CELLS and the state encoding from the shared terminal package also used by command_handler and the char buffer.
REQ-020 SHALL contain one natural sub-module, fill_counter (address incrementer with wrap at CELLS plus remaining-count down-counter); arbiter stays inline.

Verification
REQ-021 SHALL cover: A valid addr 5 char 0x41 alone -> a_ready same cycle, next cycle wen=1 waddr=5 wdata=0x41.
REQ-022 SHALL cover: A and B valid continuously 4 cycles after reset -> grants A,B,A,B; waddr alternates accordingly.
REQ-023 SHALL cover: clr_start addr 1998 count 4 char 0x20 -> writes at 1998,1999,0,1; clr_busy 4 cycles; clr_done with the write at 1; A held valid meanwhile accepted the cycle after clr_busy falls.
REQ-024 SHALL cover: clr_count 0 -> no wen, clr_done one cycle later; clr_count 3000 -> exactly 2000 writes.
REQ-025 SHALL cover: B request addr 2047 -> accepted, no wen, range_err pulse next cycle.
REQ-026 SHALL cover: reset asserted during fill at write 10 of 80 -> wen low next cycle, clr_busy 0, no clr_done; new clr_start after reset runs normally.
